// File: rtl/movement_authorization.sv
// Movement safety gate: the drive enable drops combinationally on emergency and
// is re-granted only after a startup delay or a debounced recovery holdoff.
module movement_authorization #(
    parameter int unsigned HOLDOFF_CYCLES = 8,
    parameter int unsigned STARTUP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       emergency_mode,
    output logic       moviment_authorization,
    output logic [1:0] state,
    output logic [7:0] emergency_count
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] STARTUP_LIMIT = CNT_W'(STARTUP_CYCLES);
    localparam logic [CNT_W-1:0] HOLDOFF_LIMIT = CNT_W'(HOLDOFF_CYCLES);

    typedef enum logic [1:0] {
        ST_STARTUP    = 2'd0,
        ST_AUTHORIZED = 2'd1,
        ST_EMERGENCY  = 2'd2,
        ST_RECOVERY   = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] count_sat;

    // Shared startup/holdoff counter; emergency entries saturate at all-ones
    always_comb begin
        cnt_inc   = cnt_q + CNT_W'(1);
        count_sat = (emergency_count == '1) ? emergency_count
                                            : emergency_count + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_STARTUP;
            cnt_q           <= '0;
            emergency_count <= '0;
        end else begin
            case (state_q)
                ST_STARTUP: begin
                    if (emergency_mode) begin
                        state_q         <= ST_EMERGENCY;
                        cnt_q           <= '0;
                        emergency_count <= count_sat;
                    end else if (cnt_inc == STARTUP_LIMIT) begin
                        state_q <= ST_AUTHORIZED;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_AUTHORIZED: begin
                    if (emergency_mode) begin
                        state_q         <= ST_EMERGENCY;
                        cnt_q           <= '0;
                        emergency_count <= count_sat;
                    end
                end
                ST_EMERGENCY: begin
                    if (!emergency_mode) begin
                        state_q <= ST_RECOVERY;
                        cnt_q   <= '0;
                    end
                end
                ST_RECOVERY: begin
                    // Any sampled emergency restarts the whole holdoff
                    if (emergency_mode) begin
                        state_q         <= ST_EMERGENCY;
                        cnt_q           <= '0;
                        emergency_count <= count_sat;
                    end else if (cnt_inc == HOLDOFF_LIMIT) begin
                        state_q <= ST_AUTHORIZED;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    state_q <= ST_STARTUP;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign state = state_q;

    // Emergency term bypasses all registers so the drive stops immediately
    assign moviment_authorization = (state_q == ST_AUTHORIZED) && !emergency_mode;

endmodule

// File: tb/tb_movement_authorization.sv
// Self-checking bench for movement_authorization: vector table, hand-written
// corner sequences and a queue of expected post-edge results.
module tb_movement_authorization;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       emergency_mode;
    logic       moviment_authorization;
    logic [1:0] state;
    logic [7:0] emergency_count;

    movement_authorization #(
        .HOLDOFF_CYCLES(8),
        .STARTUP_CYCLES(4)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .emergency_mode        (emergency_mode),
        .moviment_authorization(moviment_authorization),
        .state                 (state),
        .emergency_count       (emergency_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       em;
        logic [1:0] st;
        logic [7:0] cnt;
    } vec_t;

    typedef struct {
        logic       auth;
        logic [1:0] st;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb_q[$];
    vec_t       tbl[15];
    int         errors = 0;
    int         checks = 0;
    logic [1:0] last_st;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one input value between edges, check the combinational output,
    // then compare the post-edge outputs against the queued expectation.
    task automatic apply(input logic em, input logic [1:0] st, input logic [7:0] cnt,
                         input string tag);
        exp_t e;
        @(negedge clk);
        emergency_mode = em;
        #1;
        check({tag, "/comb_auth"}, 8'(moviment_authorization), 8'((last_st == 2'd1) && !em));
        e.auth = (st == 2'd1) && !em;
        e.st   = st;
        e.cnt  = cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s/scoreboard: queue empty, expected one entry", tag);
        end else begin
            checks--;
            e = sb_q.pop_front();
            check({tag, "/auth"},  8'(moviment_authorization), 8'(e.auth));
            check({tag, "/state"}, 8'(state), 8'(e.st));
            check({tag, "/count"}, emergency_count, e.cnt);
        end
        last_st = st;
    endtask

    task automatic reset_release();
        @(posedge clk);
        #2;
        rst_n   = 1'b1;
        last_st = 2'd0;
    endtask

    initial begin
        logic [7:0] exp_cnt;

        tbl = '{
            '{1'b0, 2'd0, 8'd0}, '{1'b0, 2'd0, 8'd0}, '{1'b0, 2'd0, 8'd0},
            '{1'b0, 2'd1, 8'd0},
            '{1'b1, 2'd2, 8'd1}, '{1'b1, 2'd2, 8'd1},
            '{1'b0, 2'd3, 8'd1},
            '{1'b0, 2'd3, 8'd1}, '{1'b0, 2'd3, 8'd1}, '{1'b0, 2'd3, 8'd1},
            '{1'b0, 2'd3, 8'd1}, '{1'b0, 2'd3, 8'd1}, '{1'b0, 2'd3, 8'd1},
            '{1'b0, 2'd3, 8'd1},
            '{1'b0, 2'd1, 8'd1}
        };

        rst_n          = 1'b0;
        emergency_mode = 1'b0;
        last_st        = 2'd0;
        #3;
        check("reset/auth",  8'(moviment_authorization), 8'd0);
        check("reset/state", 8'(state), 8'd0);
        check("reset/count", emergency_count, 8'd0);
        repeat (2) @(posedge clk);
        reset_release();

        // Startup, first emergency, full 9-edge recovery
        foreach (tbl[i]) apply(tbl[i].em, tbl[i].st, tbl[i].cnt, $sformatf("tbl%0d", i));

        // Glitch at holdoff cycle 5 restarts the full recovery
        apply(1'b1, 2'd2, 8'd2, "glitch_entry");
        apply(1'b0, 2'd3, 8'd2, "glitch_rec");
        repeat (4) apply(1'b0, 2'd3, 8'd2, "glitch_hold");
        apply(1'b1, 2'd2, 8'd3, "glitch_hit");
        repeat (8) apply(1'b0, 2'd3, 8'd3, "glitch_rehold");
        apply(1'b0, 2'd1, 8'd3, "glitch_regrant");

        // Sub-cycle pulse in AUTHORIZED: output drops, state unaffected
        @(negedge clk);
        emergency_mode = 1'b1;
        #0.5;
        check("pulse/drop", 8'(moviment_authorization), 8'd0);
        #1;
        emergency_mode = 1'b0;
        #0.5;
        check("pulse/restore", 8'(moviment_authorization), 8'd1);
        apply(1'b0, 2'd1, 8'd3, "pulse_after");

        // Async reset in EMERGENCY with emergency still asserted
        apply(1'b1, 2'd2, 8'd4, "pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst/state", 8'(state), 8'd0);
        check("async_rst/count", emergency_count, 8'd0);
        check("async_rst/auth",  8'(moviment_authorization), 8'd0);
        @(posedge clk);
        #1;
        check("rst_dominates/state", 8'(state), 8'd0);
        emergency_mode = 1'b0;
        reset_release();
        apply(1'b0, 2'd0, 8'd0, "restart");

        // Emergency from STARTUP, then saturation over 260 entries
        apply(1'b1, 2'd2, 8'd1, "startup_em");
        exp_cnt = 8'd1;
        for (int i = 2; i <= 260; i++) begin
            apply(1'b0, 2'd3, exp_cnt, "sat_rec");
            exp_cnt = (exp_cnt == 8'd255) ? exp_cnt : exp_cnt + 8'd1;
            apply(1'b1, 2'd2, exp_cnt, $sformatf("sat_entry%0d", i));
        end
        check("sat/final", emergency_count, 8'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
